// File: rtl/bilinear_interp_pkg.sv
// Shared RGB565 field layout, channel expand/pack helpers and the lerp
// saturation limits used by every bilinear_interp file.
package bilinear_interp_pkg;

  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

  localparam int SAT_MIN = 0;
  localparam int SAT_MAX = 255;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb8_t;

  // MSB replication keeps full-scale codes at full scale (31 -> 255, 63 -> 255).
  function automatic rgb8_t unpack565(input logic [15:0] w);
    rgb8_t c;
    c.r = {w[R_MSB:R_LSB], w[R_MSB -: 3]};
    c.g = {w[G_MSB:G_LSB], w[G_MSB -: 2]};
    c.b = {w[B_MSB:B_LSB], w[B_MSB -: 3]};
    return c;
  endfunction

  function automatic logic [15:0] pack565(input rgb8_t c);
    return {c.r[7:3], c.g[7:2], c.b[7:3]};
  endfunction

endpackage

// File: rtl/bilinear_interp_if.sv
// Pixel-quad stream interface of bilinear_interp: upstream quad/weights with
// valid/ready, downstream RGB565 pixel with valid/ready.
interface bilinear_interp_if #(
  parameter int FRAC_W = 10,
  parameter int SB_W   = 2
);
  logic              i_valid;
  logic              o_ready;
  logic [15:0]       iv_b11;
  logic [15:0]       iv_b12;
  logic [15:0]       iv_b21;
  logic [15:0]       iv_b22;
  logic [FRAC_W:0]   iv_fx;
  logic [FRAC_W:0]   iv_fy;
  logic              i_mode;
  logic              i_oob;
  logic [SB_W-1:0]   iv_sb;
  logic              o_valid;
  logic              i_ready;
  logic [15:0]       ov_pix;
  logic [SB_W-1:0]   ov_sb;

  modport master (
    output i_valid, iv_b11, iv_b12, iv_b21, iv_b22, iv_fx, iv_fy,
           i_mode, i_oob, iv_sb, i_ready,
    input  o_ready, o_valid, ov_pix, ov_sb
  );

  modport slave (
    input  i_valid, iv_b11, iv_b12, iv_b21, iv_b22, iv_fx, iv_fy,
           i_mode, i_oob, iv_sb, i_ready,
    output o_ready, o_valid, ov_pix, ov_sb
  );
endinterface

// File: rtl/bilerp_lerp8.sv
// One 8-bit channel lerp: registered signed (b-a)*f product, then a
// combinational shift/add/saturate. Round-half-up when BILERP_ROUND_EN is defined.
module bilerp_lerp8
  import bilinear_interp_pkg::*;
#(
  parameter int FRAC_W = 10
) (
  input  logic            clk,
  input  logic            en,
  input  logic [7:0]      a,
  input  logic [7:0]      b,
  input  logic [FRAC_W:0] f,
  output logic [7:0]      y
);

  localparam int PW = FRAC_W + 10;
`ifdef BILERP_ROUND_EN
  localparam logic signed [PW-1:0] HALF = {{(PW-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
`endif

  logic signed [8:0]    diff;
  logic signed [PW-1:0] diff_w;
  logic signed [PW-1:0] f_w;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] prod_p1;
  logic        [7:0]    a_p1;
  logic signed [PW-1:0] sum;

  function automatic logic signed [PW-1:0] round_shift(input logic signed [PW-1:0] p);
`ifdef BILERP_ROUND_EN
    return (p + HALF) >>> FRAC_W;
`else
    return p >>> FRAC_W;
`endif
  endfunction

  function automatic logic [7:0] sat8(input logic signed [PW-1:0] v);
    if (int'(v) < SAT_MIN) return 8'(SAT_MIN);
    if (int'(v) > SAT_MAX) return 8'(SAT_MAX);
    return v[7:0];
  endfunction

  assign diff   = $signed({1'b0, b}) - $signed({1'b0, a});
  assign diff_w = {{(PW-9){diff[8]}}, diff};
  assign f_w    = {{(PW-FRAC_W-1){1'b0}}, f};
  assign prod   = diff_w * f_w;

  // product register boundary
  always_ff @(posedge clk) begin
    if (en) begin
      prod_p1 <= prod;
      a_p1    <= a;
    end
  end

  assign sum = $signed({{(PW-8){1'b0}}, a_p1}) + round_shift(prod_p1);
  assign y   = sat8(sum);

endmodule

// File: rtl/bilinear_interp.sv
// Four-stage RGB565 bilinear / nearest-neighbour interpolator with valid/ready
// back-pressure. Optional build macro: BILERP_ROUND_EN (round-half-up lerps).
module bilinear_interp
  import bilinear_interp_pkg::*;
#(
  parameter int          FRAC_W = 10,
  parameter int          SB_W   = 2,
  parameter logic [15:0] FILL   = 16'h0000
) (
  input logic            i_clk,
  input logic            i_reset,
  bilinear_interp_if.slave bus
);

  localparam logic [FRAC_W:0] ONE    = {1'b1, {FRAC_W{1'b0}}};
  localparam logic [FRAC_W:0] HALF_W = {2'b01, {(FRAC_W-1){1'b0}}};

  logic            en;
  logic            take;
  logic [FRAC_W:0] fx_c;
  logic [FRAC_W:0] fy_c;
  logic [15:0]     near;
  logic [2:0][7:0] p11, p12, p21, p22;

  logic            vld_p1, vld_p2, vld_p3, vld_p4;
  logic [FRAC_W:0] fy_p1, fy_p2;
  logic            mode_p1, mode_p2, mode_p3;
  logic            oob_p1, oob_p2, oob_p3;
  logic [15:0]     near_p1, near_p2, near_p3;
  logic [SB_W-1:0] sb_p1, sb_p2, sb_p3, sb_p4;
  logic [15:0]     pix_p4;

  logic [7:0]      htop_y  [3];
  logic [7:0]      hbot_y  [3];
  logic [7:0]      htop_p2 [3];
  logic [7:0]      hbot_p2 [3];
  logic [7:0]      v_y     [3];
  logic [15:0]     pix_nxt;

  // Everything advances together; a stalled output freezes the whole pipe.
  assign en          = bus.i_ready | ~vld_p4;
  assign take        = bus.i_valid & en;
  assign bus.o_ready = en;

  assign fx_c = (bus.iv_fx > ONE) ? ONE : bus.iv_fx;
  assign fy_c = (bus.iv_fy > ONE) ? ONE : bus.iv_fy;

  always_comb begin
    near = bus.iv_b11;
    if (fy_c >= HALF_W) near = (fx_c >= HALF_W) ? bus.iv_b22 : bus.iv_b21;
    else                near = (fx_c >= HALF_W) ? bus.iv_b12 : bus.iv_b11;
  end

  assign p11 = unpack565(bus.iv_b11);
  assign p12 = unpack565(bus.iv_b12);
  assign p21 = unpack565(bus.iv_b21);
  assign p22 = unpack565(bus.iv_b22);

  // Index 2 = red, 1 = green, 0 = blue.
  for (genvar c = 0; c < 3; c++) begin : g_ch
    bilerp_lerp8 #(.FRAC_W(FRAC_W)) u_htop (
      .clk (i_clk),
      .en  (take),
      .a   (p11[c]),
      .b   (p12[c]),
      .f   (fx_c),
      .y   (htop_y[c])
    );
    bilerp_lerp8 #(.FRAC_W(FRAC_W)) u_hbot (
      .clk (i_clk),
      .en  (take),
      .a   (p21[c]),
      .b   (p22[c]),
      .f   (fx_c),
      .y   (hbot_y[c])
    );
    bilerp_lerp8 #(.FRAC_W(FRAC_W)) u_vert (
      .clk (i_clk),
      .en  (en & vld_p2),
      .a   (htop_p2[c]),
      .b   (hbot_p2[c]),
      .f   (fy_p2),
      .y   (v_y[c])
    );
  end

  always_comb begin
    pix_nxt = pack565(rgb8_t'({v_y[2], v_y[1], v_y[0]}));
    if (mode_p3) pix_nxt = near_p3;
    if (oob_p3)  pix_nxt = FILL;
  end

  // S1: horizontal products (inside the lerps) plus captured side data
  always_ff @(posedge i_clk) begin
    if (take) begin
      fy_p1   <= fy_c;
      mode_p1 <= bus.i_mode;
      oob_p1  <= bus.i_oob;
      near_p1 <= near;
      sb_p1   <= bus.iv_sb;
    end
    // S2: horizontal sums
    if (en && vld_p1) begin
      htop_p2 <= htop_y;
      hbot_p2 <= hbot_y;
      fy_p2   <= fy_p1;
      mode_p2 <= mode_p1;
      oob_p2  <= oob_p1;
      near_p2 <= near_p1;
      sb_p2   <= sb_p1;
    end
    // S3: vertical product (inside the lerps)
    if (en && vld_p2) begin
      mode_p3 <= mode_p2;
      oob_p3  <= oob_p2;
      near_p3 <= near_p2;
      sb_p3   <= sb_p2;
    end
  end

  // S4: vertical sum, pack and output register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
      vld_p4 <= 1'b0;
      pix_p4 <= 16'h0000;
      sb_p4  <= '0;
    end else if (en) begin
      vld_p1 <= bus.i_valid;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
      vld_p4 <= vld_p3;
      if (vld_p3) begin
        pix_p4 <= pix_nxt;
        sb_p4  <= sb_p3;
      end
    end
  end

  assign bus.o_valid = vld_p4;
  assign bus.ov_pix  = pix_p4;
  assign bus.ov_sb   = sb_p4;

endmodule

// File: tb/tb_bilinear_interp.sv
// Self-checking bench for bilinear_interp: directed corner cases plus a
// randomized stream against an arithmetic reference model.
module tb_bilinear_interp;

  localparam int          FRAC_W = 10;
  localparam int          SB_W   = 2;
  localparam logic [15:0] FILL_V = 16'h001F;
  localparam int          ONE    = 1 << FRAC_W;
`ifdef BILERP_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [17:0] sbq[$];

  bilinear_interp_if #(.FRAC_W(FRAC_W), .SB_W(SB_W)) bus ();

  bilinear_interp #(.FRAC_W(FRAC_W), .SB_W(SB_W), .FILL(FILL_V)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int chan(input logic [15:0] w, input int sel);
    int v;
    case (sel)
      0:       begin v = int'(w[15:11]); return v * 8 + v / 4;  end
      1:       begin v = int'(w[10:5]);  return v * 4 + v / 16; end
      default: begin v = int'(w[4:0]);   return v * 8 + v / 4;  end
    endcase
  endfunction

  function automatic int lerp(input int a, input int b, input int f);
    int p, v;
    p = (b - a) * f + RND * (ONE / 2);
    v = a + (p >>> FRAC_W);
    if (v < 0)   v = 0;
    if (v > 255) v = 255;
    return v;
  endfunction

  function automatic logic [15:0] model(input logic [15:0] b11, b12, b21, b22,
                                        input logic [10:0] fx, fy,
                                        input logic mode, oob);
    int fxc, fyc;
    int o[3];
    if (oob) return FILL_V;
    fxc = (int'(fx) > ONE) ? ONE : int'(fx);
    fyc = (int'(fy) > ONE) ? ONE : int'(fy);
    if (mode) begin
      if (fyc >= ONE / 2) return (fxc >= ONE / 2) ? b22 : b21;
      return (fxc >= ONE / 2) ? b12 : b11;
    end
    for (int c = 0; c < 3; c++)
      o[c] = lerp(lerp(chan(b11, c), chan(b12, c), fxc),
                  lerp(chan(b21, c), chan(b22, c), fxc), fyc);
    return 16'((o[0] / 8) * 2048 + (o[1] / 4) * 32 + o[2] / 8);
  endfunction

  function automatic logic [15:0] word(input int i);
    return 16'(3840 + i * 291);
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic drive(input logic v, input logic [15:0] b11, b12, b21, b22,
                       input logic [10:0] fx, fy, input logic mode, oob,
                       input logic [1:0] sb);
    bus.i_valid = v;
    bus.iv_b11 = b11; bus.iv_b12 = b12; bus.iv_b21 = b21; bus.iv_b22 = b22;
    bus.iv_fx = fx; bus.iv_fy = fy; bus.i_mode = mode; bus.i_oob = oob;
    bus.iv_sb = sb;
  endtask

  // Sends one quad into an empty pipe and reports latency (cycles, -1 = none) and result.
  task automatic run_one(input logic [15:0] b11, b12, b21, b22,
                         input logic [10:0] fx, fy, input logic mode, oob,
                         input logic [1:0] sb,
                         output logic [15:0] pix, output logic [1:0] sbo, output int lat);
    @(negedge clk);
    bus.i_ready = 1'b1;
    drive(1'b1, b11, b12, b21, b22, fx, fy, mode, oob, sb);
    lat = -1;
    pix = 'x;
    sbo = 'x;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 1) bus.i_valid = 1'b0;
      if (bus.o_valid === 1'b1 && lat < 0) begin
        lat = k; pix = bus.ov_pix; sbo = bus.ov_sb;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.o_valid); end
    checks++; if (bus.ov_pix !== 16'h0000) begin errors++; $display("FAIL reset_pix got %h want 0000", bus.ov_pix); end
    checks++; if (bus.ov_sb !== 2'b00) begin errors++; $display("FAIL reset_sb got %b want 00", bus.ov_sb); end
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.o_ready); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_solid();
    logic [15:0] pix; logic [1:0] sbo; int lat;
    run_one(16'hF800, 16'hF800, 16'hF800, 16'hF800, 11'd512, 11'd512, 1'b0, 1'b0, 2'b10, pix, sbo, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL solid_latency got %0d want 4", lat); end
    checks++; if (pix !== 16'hF800) begin errors++; $display("FAIL solid_pix got %h want f800", pix); end
    checks++; if (sbo !== 2'b10) begin errors++; $display("FAIL solid_sb got %b want 10", sbo); end
  endtask

  task automatic test_horizontal();
    logic [10:0] fxs[4];
    logic [15:0] exps[4];
    logic [15:0] pix; logic [1:0] sbo; int lat;
    fxs  = '{11'd1024, 11'd0, 11'd2047, 11'd512};
    exps = '{16'hFFFF, 16'h0000, 16'hFFFF, (RND != 0) ? 16'h8410 : 16'h7BEF};
    for (int i = 0; i < 4; i++) begin
      run_one(16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, fxs[i], 11'd0, 1'b0, 1'b0, 2'(i), pix, sbo, lat);
      checks++;
      if (pix !== exps[i] || lat !== 4)
        begin errors++; $display("FAIL horiz_fx%0d got %h lat %0d want %h lat 4", fxs[i], pix, lat, exps[i]); end
    end
  endtask

  task automatic test_nearest_oob();
    logic [15:0] pix; logic [1:0] sbo; int lat;
    run_one(16'hAAAA, 16'h1234, 16'h5555, 16'h7777, 11'd513, 11'd100, 1'b1, 1'b0, 2'b01, pix, sbo, lat);
    checks++; if (pix !== 16'h1234) begin errors++; $display("FAIL nearest_b12 got %h want 1234", pix); end
    run_one(16'hAAAA, 16'h1234, 16'h5555, 16'h7777, 11'd100, 11'd600, 1'b1, 1'b0, 2'b11, pix, sbo, lat);
    checks++; if (pix !== 16'h5555) begin errors++; $display("FAIL nearest_b21 got %h want 5555", pix); end
    checks++; if (sbo !== 2'b11) begin errors++; $display("FAIL nearest_sb got %b want 11", sbo); end
    run_one(16'hAAAA, 16'h1234, 16'h5555, 16'h7777, 11'd300, 11'd700, 1'b0, 1'b1, 2'b00, pix, sbo, lat);
    checks++; if (pix !== FILL_V) begin errors++; $display("FAIL oob_bilinear got %h want %h", pix, FILL_V); end
    run_one(16'hAAAA, 16'h1234, 16'h5555, 16'h7777, 11'd900, 11'd900, 1'b1, 1'b1, 2'b00, pix, sbo, lat);
    checks++; if (pix !== FILL_V) begin errors++; $display("FAIL oob_nearest got %h want %h", pix, FILL_V); end
  endtask

  task automatic test_random();
    logic [15:0] w[4];
    logic [10:0] fx, fy;
    logic        md, ob, v;
    logic [1:0]  sb;
    logic [17:0] exp_v, held;
    logic        was_stall;
    sbq.delete();
    was_stall = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 420; cyc++) begin
      @(negedge clk);
      for (int j = 0; j < 4; j++) w[j] = 16'($urandom);
      fx = 11'($urandom_range(0, 1500));
      fy = 11'($urandom_range(0, 1500));
      md = ($urandom_range(0, 3) == 0);
      ob = ($urandom_range(0, 9) == 0);
      sb = 2'($urandom);
      v  = (cyc < 400) && ($urandom_range(0, 3) != 0);
      drive(v, w[0], w[1], w[2], w[3], fx, fy, md, ob, sb);
      bus.i_ready = (cyc >= 400) || ($urandom_range(0, 9) < 7);
      #1;
      if (was_stall) begin
        checks++;
        if ({bus.ov_pix, bus.ov_sb} !== held || bus.o_valid !== 1'b1)
          begin errors++; $display("FAIL rand_hold got %h want %h", {bus.ov_pix, bus.ov_sb}, held); end
      end
      was_stall = bus.o_valid && !bus.i_ready;
      held = {bus.ov_pix, bus.ov_sb};
      if (bus.o_valid === 1'b1 && bus.i_ready) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++; $display("FAIL rand_extra got %h want none", {bus.ov_pix, bus.ov_sb});
        end else begin
          exp_v = sbq.pop_front();
          if ({bus.ov_pix, bus.ov_sb} !== exp_v)
            begin errors++; $display("FAIL rand_pix got %h want %h", {bus.ov_pix, bus.ov_sb}, exp_v); end
        end
      end
      if (bus.i_valid && bus.o_ready === 1'b1)
        sbq.push_back({model(w[0], w[1], w[2], w[3], fx, fy, md, ob), sb});
    end
    checks++;
    if (sbq.size() != 0) begin errors++; $display("FAIL rand_lost got %0d left want 0", sbq.size()); end
  endtask

  task automatic test_stall();
    int sent, got;
    logic stall;
    logic [17:0] held;
    sent = 0; got = 0; held = '0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      stall = (cyc >= 4 && cyc <= 6);
      bus.i_ready = !stall;
      drive(sent < 8, word(sent), 16'h0, 16'h0, 16'h0, 11'd0, 11'd0, 1'b1, 1'b0, 2'(sent));
      #1;
      if (stall) begin
        checks++;
        if (bus.o_ready !== 1'b0 || bus.o_valid !== 1'b1)
          begin errors++; $display("FAIL stall_ready got rdy %b vld %b want rdy 0 vld 1", bus.o_ready, bus.o_valid); end
        if (cyc == 4) held = {bus.ov_pix, bus.ov_sb};
        else begin
          checks++;
          if ({bus.ov_pix, bus.ov_sb} !== held)
            begin errors++; $display("FAIL stall_hold got %h want %h", {bus.ov_pix, bus.ov_sb}, held); end
        end
      end
      if (bus.o_valid === 1'b1 && bus.i_ready) begin
        checks++;
        if (got >= 8 || {bus.ov_pix, bus.ov_sb} !== {word(got), 2'(got)})
          begin errors++; $display("FAIL stall_order idx %0d got %h want %h", got, {bus.ov_pix, bus.ov_sb}, {word(got), 2'(got)}); end
        got++;
      end
      if (bus.i_valid && bus.o_ready === 1'b1) sent++;
    end
    checks++;
    if (got != 8 || sent != 8) begin errors++; $display("FAIL stall_count got %0d out %0d in want 8 8", got, sent); end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.i_ready = 1'b1;
      drive(1'b1, 16'hABCD, 16'hABCD, 16'hABCD, 16'hABCD, 11'd0, 11'd0, 1'b1, 1'b0, 2'b11);
    end
    @(negedge clk);
    bus.i_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", bus.o_valid); end
    checks++; if (bus.ov_pix !== 16'h0000) begin errors++; $display("FAIL midrst_pix got %h want 0000", bus.ov_pix); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", bus.o_ready); end
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale cycle %0d got %h want no output", k, bus.ov_pix); end
    end
  endtask

  initial begin
    drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 11'd0, 11'd0, 1'b0, 1'b0, 2'b00);
    bus.i_ready = 1'b1;
    test_reset();
    test_solid();
    test_horizontal();
    test_nearest_oob();
    test_random();
    test_stall();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
